// File: rtl/cntr_capture_fifo.sv
// Multi-channel counter capture: per-channel holding regs, round-robin arbiter, FWFT word FIFO.
// Latency: capture at edge E, push at E+1, head visible after E+1 (2 clocks minimum).
// Backpressure: full FIFO withholds grants; values wait in holding regs, and a further capture overwrites them.
module cntr_capture_fifo #(
  parameter int NCH    = 4,
  parameter int CNTR_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH*CNTR_W-1:0]     cntr,
  input  logic [NCH-1:0]            cntr_valid,
  output logic [31:0]               data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_read,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [CNTR_W-1:0] hold [NCH];
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    ovr;
  logic [CW-1:0]     rr_ptr;     // first channel examined by the arbiter
  logic [6:0]        seq;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;

  logic              pop;
  logic              can_push;
  logic              gnt;
  logic [CW-1:0]     gnt_ch;
  logic [NCH-1:0]    gnt_vec;
  logic [NCH-1:0]    ovw;
  logic [31:0]       push_word;
  logic [16:0]       drop_sum;
  int                idx;

  assign data_out_valid = (level != '0);
  assign fifo_level     = level;
  assign data_out       = data_out_valid ? mem[rd_ptr] : 32'h0;
  assign pop            = data_out_read & data_out_valid;
  assign can_push       = (level < FULL_LVL) | pop;

  // Round-robin search for the first pending channel starting at rr_ptr
  always_comb begin
    gnt     = 1'b0;
    gnt_ch  = '0;
    gnt_vec = '0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!gnt && can_push && pend[idx]) begin
        gnt          = 1'b1;
        gnt_ch       = CW'(idx);
        gnt_vec[idx] = 1'b1;
      end
    end
  end

  // Word assembly, overwrite detection and saturating drop accumulation
  always_comb begin
    push_word = {4'(gnt_ch), ovr[gnt_ch], seq, 20'(hold[gnt_ch])};
    ovw       = cntr_valid & pend & ~gnt_vec;
    drop_sum  = {1'b0, drop_cnt} + 17'($countones(ovw));
  end

  // Capture stage, arbiter pointer, sequence counter and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) hold[c] <= '0;
      pend     <= '0;
      ovr      <= '0;
      rr_ptr   <= '0;
      seq      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cntr_valid[c]) hold[c] <= cntr[c*CNTR_W +: CNTR_W];
      end
      // a capture on the granted edge re-arms pend; the old value is what gets pushed
      pend <= cntr_valid | (pend & ~gnt_vec);
      ovr  <= ovw | (ovr & ~gnt_vec);
      if (gnt) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 1'b1;
        rr_ptr <= CW'((int'(gnt_ch) + 1) % NCH);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({gnt, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (gnt) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_cntr_capture_fifo.sv
module tb_cntr_capture_fifo;
  localparam int NCH    = 4;
  localparam int CNTR_W = 10;
  localparam int DEPTH  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH*CNTR_W-1:0] cntr;
  logic [NCH-1:0]        cntr_valid;
  logic [31:0]           data_out;
  logic                  data_out_valid;
  logic                  data_out_read;
  logic [4:0]            fifo_level;
  logic [15:0]           drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: queue of words plus per-channel capture state
  logic [31:0] m_q[$];
  int          m_pend[NCH];
  int          m_ovr[NCH];
  int          m_hold[NCH];
  int          m_last;
  int          m_seq;
  int          m_drop;

  always #5 clk = ~clk;

  cntr_capture_fifo #(.NCH(NCH), .CNTR_W(CNTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cntr(cntr), .cntr_valid(cntr_valid),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_read(data_out_read),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  function automatic logic [NCH*CNTR_W-1:0] pack1(input int ch, input int v);
    logic [NCH*CNTR_W-1:0] r;
    r = '0;
    r[ch*CNTR_W +: CNTR_W] = CNTR_W'(v);
    return r;
  endfunction

  function automatic logic [NCH*CNTR_W-1:0] rand_cn();
    logic [NCH*CNTR_W-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*CNTR_W +: CNTR_W] = CNTR_W'($urandom);
    return r;
  endfunction

  // apply inputs, take one edge, advance the model with the same inputs, settle
  task automatic step(input logic [NCH-1:0] cv, input logic [NCH*CNTR_W-1:0] cn,
                      input logic rd, input logic r);
    int g, ch;
    bit popq, canp;
    logic [31:0] w;
    cntr_valid = cv; cntr = cn; data_out_read = rd; rst = r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      for (int c = 0; c < NCH; c++) begin m_pend[c] = 0; m_ovr[c] = 0; m_hold[c] = 0; end
      m_last = NCH - 1; m_seq = 0; m_drop = 0;
    end else begin
      popq = rd && (m_q.size() > 0);
      canp = (m_q.size() < DEPTH) || popq;
      g = -1;
      if (canp) begin
        for (int k = 1; k <= NCH; k++) begin
          ch = (m_last + k) % NCH;
          if (g < 0 && m_pend[ch] != 0) g = ch;
        end
      end
      if (popq) void'(m_q.pop_front());
      if (g >= 0) begin
        w = (32'(g) << 28) | (32'(m_ovr[g]) << 27) | (32'(m_seq) << 20) | 32'(m_hold[g]);
        m_q.push_back(w);
        m_seq = (m_seq + 1) % 128;
        m_last = g;
        m_pend[g] = 0;
        m_ovr[g] = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (cv[c]) begin
          if (m_pend[c] != 0) begin
            m_ovr[c] = 1;
            if (m_drop < 65535) m_drop++;
          end
          m_pend[c] = 1;
          m_hold[c] = int'(cn[c*CNTR_W +: CNTR_W]);
        end
      end
    end
    #1;
  endtask

  task automatic fill16();
    for (int i = 0; i < DEPTH; i++) step(NCH'(1 << (i % NCH)), rand_cn(), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    n_chk++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", data_out_valid); end
    n_chk++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_chk++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    n_chk++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %08h expected 0", data_out); end
  endtask

  task automatic test_first_word();
    step(4'b0001, pack1(0, 800), 1'b0, 1'b0);
    n_chk++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid: got %0b expected 0", data_out_valid); end
    step('0, '0, 1'b0, 1'b0);
    n_chk++; if (data_out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %0b expected 1", data_out_valid); end
    n_chk++; if (data_out !== 32'h0000_0320) begin n_fail++; $display("FAIL t1_word: got %08h expected 00000320", data_out); end
    n_chk++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL t1_level: got %0d expected 1", fifo_level); end
    step('0, '0, 1'b1, 1'b0);
    n_chk++; if (data_out_valid !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL t1_after_read: got valid %0b level %0d expected 0 0", data_out_valid, fifo_level); end
  endtask

  task automatic test_all_channels();
    logic [31:0] exp;
    step('0, '0, 1'b0, 1'b1);
    step(4'hF, pack1(0, 10) | pack1(1, 20) | pack1(2, 30) | pack1(3, 40), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step('0, '0, 1'b0, 1'b0);
      n_chk++; if (fifo_level !== 5'(i + 1)) begin n_fail++; $display("FAIL t2_level%0d: got %0d expected %0d", i, fifo_level, i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      exp = (32'(i) << 28) | (32'(i) << 20) | 32'((i + 1) * 10);
      n_chk++; if (data_out !== exp) begin n_fail++; $display("FAIL t2_word%0d: got %08h expected %08h", i, data_out, exp); end
      step('0, '0, 1'b1, 1'b0);
    end
    n_chk++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL t2_empty: got %0b expected 0", data_out_valid); end
  endtask

  task automatic test_overwrite_full();
    int a, b;
    logic [31:0] exp;
    step('0, '0, 1'b0, 1'b1);
    fill16();
    n_chk++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL t3_full: got %0d expected 16", fifo_level); end
    a = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
    step(4'b0100, pack1(2, a), 1'b0, 1'b0);
    step(4'b0100, pack1(2, b), 1'b0, 1'b0);
    n_chk++; if (drop_cnt !== 16'd1 || fifo_level !== 5'd16) begin n_fail++; $display("FAIL t3_drop: got drop %0d level %0d expected 1 16", drop_cnt, fifo_level); end
    step('0, '0, 1'b1, 1'b0);
    n_chk++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL t3_poppush_level: got %0d expected 16", fifo_level); end
    exp = (32'd2 << 28) | (32'd1 << 27) | (32'd16 << 20) | 32'(b);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_q.size() > 0) begin
        n_chk++; if (data_out !== m_q[0]) begin n_fail++; $display("FAIL t3_drain%0d: got %08h expected %08h", i, data_out, m_q[0]); end
      end
      if (i == DEPTH - 1) begin
        n_chk++; if (data_out !== exp) begin n_fail++; $display("FAIL t3_ovr_word: got %08h expected %08h", data_out, exp); end
      end
      step('0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full_popush();
    step('0, '0, 1'b0, 1'b1);
    fill16();
    step(4'b0010, pack1(1, $urandom_range(0, 1023)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(NCH'(1 << $urandom_range(0, NCH - 1)), rand_cn(), 1'b1, 1'b0);
      n_chk++; if (fifo_level !== 5'd16 || data_out !== m_q[0]) begin n_fail++; $display("FAIL t4_cycle%0d: got level %0d word %08h expected 16 %08h", i, fifo_level, data_out, m_q[0]); end
    end
    for (int i = 0; i < DEPTH + 8; i++) begin
      if (m_q.size() > 0) begin
        n_chk++; if (data_out !== m_q[0]) begin n_fail++; $display("FAIL t4_drain%0d: got %08h expected %08h", i, data_out, m_q[0]); end
      end
      step('0, '0, 1'b1, 1'b0);
    end
    n_chk++; if (fifo_level !== 5'd0 || drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL t4_end: got level %0d drop %0d expected 0 %0d", fifo_level, drop_cnt, m_drop); end
  endtask

  task automatic test_seq_wrap();
    int npop;
    npop = 0;
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 140; i++) begin
      if (data_out_valid) begin
        n_chk++; if (data_out[26:20] !== 7'(npop % 128) || data_out !== m_q[0]) begin n_fail++; $display("FAIL t5_seq%0d: got %08h expected seq %0d word %08h", npop, data_out, npop % 128, m_q[0]); end
        npop++;
      end
      step((i < 130) ? NCH'(1 << (i % NCH)) : '0, rand_cn(), 1'b1, 1'b0);
    end
    n_chk++; if (npop !== 130) begin n_fail++; $display("FAIL t5_count: got %0d words expected 130", npop); end
  endtask

  task automatic test_drop_sat();
    step('0, '0, 1'b0, 1'b1);
    fill16();
    for (int i = 0; i < 17500; i++) begin
      step(4'hF, rand_cn(), 1'b0, 1'b0);
      if (i == 9999) begin
        n_chk++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL t5_drop_mid: got %0d expected %0d", drop_cnt, m_drop); end
      end
    end
    n_chk++; if (drop_cnt !== 16'hFFFF || fifo_level !== 5'd16) begin n_fail++; $display("FAIL t5_drop_sat: got drop %04h level %0d expected FFFF 16", drop_cnt, fifo_level); end
  endtask

  task automatic test_mid_reset();
    int v;
    logic [31:0] exp;
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(NCH'(1 << (i % NCH)), rand_cn(), 1'b0, 1'b0);
    step(4'b0010, rand_cn(), 1'b0, 1'b0);
    n_chk++; if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL t6_level5: got %0d expected 5", fifo_level); end
    step(4'hF, rand_cn(), 1'b1, 1'b1);
    n_chk++; if (data_out_valid !== 1'b0 || fifo_level !== 5'd0 || data_out !== 32'h0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_after_rst: got valid %0b level %0d word %08h drop %0d expected 0 0 0 0", data_out_valid, fifo_level, data_out, drop_cnt); end
    step('0, '0, 1'b0, 1'b0);
    n_chk++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL t6_no_stale: got valid %0b expected 0", data_out_valid); end
    v = $urandom_range(0, 1023);
    step(4'b1000, pack1(3, v), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    exp = (32'd3 << 28) | 32'(v);
    n_chk++; if (data_out_valid !== 1'b1 || data_out !== exp) begin n_fail++; $display("FAIL t6_post_word: got valid %0b word %08h expected 1 %08h", data_out_valid, data_out, exp); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic rd;
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(NCH'($urandom & $urandom), rand_cn(), rd, 1'b0);
      exp = (m_q.size() > 0) ? m_q[0] : 32'h0;
      n_chk++;
      if (data_out_valid !== (m_q.size() > 0) || fifo_level !== 5'(m_q.size()) ||
          data_out !== exp || drop_cnt !== 16'(m_drop)) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got v%0b l%0d w%08h d%0d expected v%0b l%0d w%08h d%0d",
                 i, data_out_valid, fifo_level, data_out, drop_cnt,
                 (m_q.size() > 0), m_q.size(), exp, m_drop);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cntr = '0; cntr_valid = '0; data_out_read = 1'b0;
    test_reset();
    test_first_word();
    test_all_channels();
    test_overwrite_full();
    test_full_popush();
    test_seq_wrap();
    test_drop_sat();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
